light_hash: RTL and testbench



---
 rtl/light_hash.sv | 135 +++++++++++++
 tb/tb_light_hash.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/light_hash.sv
// light_hash: byte-serial 64-bit hash over ASCII alphanumeric characters.
// Each accepted character is mixed into H[0..7] for ROUNDS passes of eight
// single-byte S-box updates; a NUL publishes the digest and reloads the IV.
module light_hash #(
  parameter int          ROUNDS = 32,
  parameter logic [63:0] IV     = 64'h34550F14DAC02BEE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ptxt_char,
  input  logic        ptxt_valid,
  output logic [63:0] digest_char,
  output logic        digest_ready,
  output logic        err_invalid_ptxt_char
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST_R = RW'(ROUNDS - 1);

  // AES forward S-box
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, ABSORB} state_t;

  state_t          state, state_d;
  // H0 lives in h[7] so the packed vector reads {H0..H7} MSB-first
  logic [7:0][7:0] h, h_d;
  logic [7:0]      m, m_d;
  logic [2:0]      j, j_d;
  logic [RW-1:0]   r, r_d;
  logic            next_byte, next_byte_d;
  logic [63:0]     digest_d;
  logic            ready_d, err_d;

  logic            is_alnum;
  logic [2:0]      src_j;
  logic [7:0]      mix;

  assign is_alnum = (ptxt_char >= 8'h30 && ptxt_char <= 8'h39) ||
                    (ptxt_char >= 8'h41 && ptxt_char <= 8'h5A) ||
                    (ptxt_char >= 8'h61 && ptxt_char <= 8'h7A);

  // H[j] ^= SBOX(H[j+2] ^ M); j+2 wraps in 3 bits so j=6,7 see updated H0,H1
  assign src_j = j + 3'd2;
  assign mix   = SBOX[h[3'd7 - src_j] ^ m] ^ h[3'd7 - j];

  // state register and all datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      h                     <= IV;
      m                     <= '0;
      j                     <= '0;
      r                     <= '0;
      next_byte             <= 1'b0;
      digest_char           <= '0;
      digest_ready          <= 1'b0;
      err_invalid_ptxt_char <= 1'b0;
    end else begin
      state                 <= state_d;
      h                     <= h_d;
      m                     <= m_d;
      j                     <= j_d;
      r                     <= r_d;
      next_byte             <= next_byte_d;
      digest_char           <= digest_d;
      digest_ready          <= ready_d;
      err_invalid_ptxt_char <= err_d;
    end
  end

  // next-state: accept/reject/finalize in IDLE, one byte update per cycle in ABSORB
  always_comb begin
    state_d     = state;
    h_d         = h;
    m_d         = m;
    j_d         = j;
    r_d         = r;
    next_byte_d = next_byte;
    digest_d    = digest_char;
    ready_d     = digest_ready;
    err_d       = 1'b0;
    case (state)
      IDLE: begin
        if (ptxt_valid) begin
          if (ptxt_char == 8'h00) begin
            digest_d = h;
            ready_d  = 1'b1;
            h_d      = IV;
          end else if (is_alnum) begin
            m_d         = ptxt_char;
            next_byte_d = 1'b1;
            ready_d     = 1'b0;
            j_d         = '0;
            r_d         = '0;
            state_d     = ABSORB;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ABSORB: begin
        h_d[3'd7 - j] = mix;
        j_d           = j + 3'd1;
        if (j == 3'd7) begin
          if (r == LAST_R) begin
            next_byte_d = 1'b0;
            state_d     = IDLE;
          end else begin
            r_d = r + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_light_hash.sv
// Directed bench for light_hash; digests come from an independent model whose
// S-box is derived from GF(2^8) inversion plus the AES affine map.
module tb_light_hash;

  localparam logic [63:0] IV = 64'h34550F14DAC02BEE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ptxt_char = 8'h00;
  logic        ptxt_valid = 1'b0;
  logic [63:0] digest_char;
  logic        digest_ready;
  logic        err_invalid_ptxt_char;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_t [256];

  light_hash dut (
    .clk(clk), .rst_n(rst_n), .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid),
    .digest_char(digest_char), .digest_ready(digest_ready),
    .err_invalid_ptxt_char(err_invalid_ptxt_char)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [63:0] model(input string s);
    logic [7:0] hh [8];
    logic [63:0] out;
    for (int i = 0; i < 8; i++) hh[i] = IV[63-8*i -: 8];
    for (int c = 0; c < s.len(); c++)
      for (int rr = 0; rr < 32; rr++)
        for (int jj = 0; jj < 8; jj++)
          hh[jj] = sbox_t[hh[(jj + 2) % 8] ^ s[c]] ^ hh[jj];
    for (int i = 0; i < 8; i++) out[63-8*i -: 8] = hh[i];
    return out;
  endfunction

  // present one character for one cycle; returns at the negedge after the sampling edge
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    ptxt_char  = c;
    ptxt_valid = 1'b1;
    @(negedge clk);
    ptxt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dut.next_byte && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (dut.next_byte) chk("busy_timeout", 64'(dut.next_byte), 64'd0);
  endtask

  task automatic hash_msg(input string s, input string tag, output logic [63:0] d);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (i == 0) chk({tag, "_ready_drop"}, 64'(digest_ready), 64'd0);
      wait_idle();
    end
    send(8'h00);
    chk({tag, "_ready"}, 64'(digest_ready), 64'd1);
    chk({tag, "_digest"}, digest_char, model(s));
    d = digest_char;
  endtask

  initial begin
    logic [63:0] d_hello, d_w1, d_w2, d_w3;
    int busy;
    build_sbox();

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_digest", digest_char, 64'd0);
    chk("reset_ready", 64'(digest_ready), 64'd0);
    chk("reset_err", 64'(err_invalid_ptxt_char), 64'd0);
    rst_n = 1'b1;

    // empty message
    send(8'h00);
    chk("empty_ready", 64'(digest_ready), 64'd1);
    chk("empty_digest", digest_char, IV);

    // invalid characters: one-cycle error, digest kept
    send(8'hFF);
    chk("err_ff", 64'(err_invalid_ptxt_char), 64'd1);
    chk("err_ff_ready_kept", 64'(digest_ready), 64'd1);
    @(negedge clk);
    chk("err_ff_pulse_end", 64'(err_invalid_ptxt_char), 64'd0);
    send(8'h20);
    chk("err_20", 64'(err_invalid_ptxt_char), 64'd1);
    @(negedge clk);
    chk("err_20_pulse_end", 64'(err_invalid_ptxt_char), 64'd0);
    send(8'h7B);
    chk("err_7b", 64'(err_invalid_ptxt_char), 64'd1);
    chk("err_7b_digest_kept", digest_char, IV);
    @(negedge clk);
    chk("err_7b_pulse_end", 64'(err_invalid_ptxt_char), 64'd0);
    send(8'h00);
    chk("after_err_digest", digest_char, IV);
    chk("after_err_ready", 64'(digest_ready), 64'd1);

    // busy timing with an ignored character mid-absorb
    send(8'h61);
    chk("busy_ready_drop", 64'(digest_ready), 64'd0);
    busy = 0;
    while (dut.next_byte && busy < 1000) begin
      busy++;
      if (busy == 100) begin ptxt_char = 8'h62; ptxt_valid = 1'b1; end
      if (busy == 101) begin
        ptxt_valid = 1'b0;
        chk("busy_no_err", 64'(err_invalid_ptxt_char), 64'd0);
      end
      @(negedge clk);
    end
    chk("busy_cycles", 64'(busy), 64'd256);
    send(8'h00);
    chk("a_digest", digest_char, model("a"));

    // full alphabet
    hash_msg("abcdefghijklmnopqrstuvwxyz", "alpha", d_hello);

    // message independence
    hash_msg("Hello", "hello", d_hello);
    hash_msg("World123456789", "w1", d_w1);
    hash_msg("World123456780", "w2", d_w2);
    chk("w_digests_differ", 64'(d_w1 !== d_w2), 64'd1);

    // async reset mid-absorb aborts the message
    send(8'h41);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_digest", digest_char, 64'd0);
    chk("midreset_ready", 64'(digest_ready), 64'd0);
    chk("midreset_err", 64'(err_invalid_ptxt_char), 64'd0);
    chk("midreset_busy", 64'(dut.next_byte), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h00);
    chk("postreset_empty", digest_char, IV);

    // fresh run after reset matches the earlier digest
    hash_msg("World123456789", "w1_fresh", d_w3);
    chk("w1_repeatable", d_w3, d_w1);

    // repeated NUL re-finalizes to IV and keeps ready
    send(8'h00);
    chk("renul_digest", digest_char, IV);
    chk("renul_ready", 64'(digest_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
